// File: rtl/ysyx_25040111_lsu_store_pkg.sv
// ysyx_25040111_lsu_store_pkg: shared encodings for the store engine and lane formatter
package ysyx_25040111_lsu_store_pkg;
    typedef enum logic [1:0] {SZ_B = 2'b00, SZ_H = 2'b01, SZ_W = 2'b10, SZ_ILL = 2'b11} size_t;
    typedef enum logic [1:0] {C_OK = 2'b00, C_MIS = 2'b01, C_BUS = 2'b10, C_TMO = 2'b11} cause_t;
    typedef enum logic [1:0] {S_IDLE, S_REQ, S_RESP, S_DONE} state_t;
    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_EXOKAY = 2'b01;
    localparam logic [1:0] RESP_SLVERR = 2'b10;
    localparam logic [1:0] RESP_DECERR = 2'b11;
endpackage

// File: rtl/ysyx_25040111_store_fmt.sv
// ysyx_25040111_store_fmt: lane-aligns store data, builds byte strobes, flags misalignment
module ysyx_25040111_store_fmt
    import ysyx_25040111_lsu_store_pkg::*;
(
    input  logic [1:0]  size,
    input  logic [1:0]  off,
    input  logic [31:0] data,
    output logic [31:0] wdata,
    output logic [3:0]  wstrb,
    output logic        misaligned
);
    always_comb begin
        wdata      = data << {off, 3'b000};
        wstrb      = size == SZ_B ? 4'b0001 << off :
                     size == SZ_H ? 4'b0011 << off :
                     size == SZ_W ? 4'b1111 : 4'b0000;
        misaligned = size == SZ_ILL || (size == SZ_H && off[0]) || (size == SZ_W && off != 2'b00);
    end
endmodule

// File: rtl/ysyx_25040111_lsu_store.sv
// ysyx_25040111_lsu_store: performs one decoded store as a single AXI4-Lite write transaction
module ysyx_25040111_lsu_store
    import ysyx_25040111_lsu_store_pkg::*;
#(
    parameter int ADDR_W       = 32,
    parameter int RESP_TIMEOUT = 255
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [ADDR_W-1:0] in_addr,
    input  logic [31:0]       in_data,
    input  logic [1:0]        in_size,
    output logic              awvalid,
    input  logic              awready,
    output logic [ADDR_W-1:0] awaddr,
    output logic              wvalid,
    input  logic              wready,
    output logic [31:0]       wdata,
    output logic [3:0]        wstrb,
    input  logic              bvalid,
    output logic              bready,
    input  logic [1:0]        bresp,
    output logic              out_valid,
    input  logic              out_ready,
    output logic              out_err,
    output logic [1:0]        out_cause
);
    localparam int CW = RESP_TIMEOUT > 1 ? $clog2(RESP_TIMEOUT) : 1;
    localparam logic [CW-1:0] LAST = CW'(RESP_TIMEOUT - 1);

    state_t            state, state_n;
    cause_t            cause, cause_n;
    logic              aw_done, aw_done_n, w_done, w_done_n, err, err_n;
    logic [CW-1:0]     cnt, cnt_n;
    logic [ADDR_W-1:0] addr_q;
    logic [31:0]       wdata_q, f_wdata;
    logic [3:0]        wstrb_q, f_wstrb;
    logic              f_mis;

    ysyx_25040111_store_fmt u_fmt (
        .size      (in_size),
        .off       (in_addr[1:0]),
        .data      (in_data),
        .wdata     (f_wdata),
        .wstrb     (f_wstrb),
        .misaligned(f_mis)
    );

    assign in_ready  = state == S_IDLE;
    assign awvalid   = state == S_REQ && !aw_done;
    assign wvalid    = state == S_REQ && !w_done;
    assign bready    = state == S_RESP;
    assign out_valid = state == S_DONE;
    assign out_err   = err;
    assign out_cause = cause;
    assign awaddr    = addr_q;
    assign wdata     = wdata_q;
    assign wstrb     = wstrb_q;

    always_comb begin
        state_n   = state;
        aw_done_n = aw_done;
        w_done_n  = w_done;
        cnt_n     = cnt;
        err_n     = err;
        cause_n   = cause;
        case (state)
            S_IDLE: if (in_valid) begin
                aw_done_n = 1'b0;
                w_done_n  = 1'b0;
                state_n   = f_mis ? S_DONE : S_REQ;
                err_n     = f_mis;
                cause_n   = f_mis ? C_MIS : C_OK;
            end
            S_REQ: begin
                aw_done_n = aw_done | (awvalid & awready);
                w_done_n  = w_done | (wvalid & wready);
                if (aw_done_n && w_done_n) begin
                    state_n = S_RESP;
                    cnt_n   = '0;
                end
            end
            S_RESP: if (bvalid) begin
                state_n = S_DONE;
                err_n   = bresp[1];
                cause_n = bresp[1] ? C_BUS : C_OK;
            end else if (RESP_TIMEOUT != 0 && cnt == LAST) begin
                state_n = S_DONE;
                err_n   = 1'b1;
                cause_n = C_TMO;
            end else begin
                cnt_n = cnt + 1'b1;
            end
            S_DONE: if (out_ready) begin
                state_n = S_IDLE;
                err_n   = 1'b0;
                cause_n = C_OK;
            end
            default: state_n = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= S_IDLE;
            aw_done <= 1'b0;
            w_done  <= 1'b0;
            cnt     <= '0;
            err     <= 1'b0;
            cause   <= C_OK;
            addr_q  <= '0;
            wdata_q <= '0;
            wstrb_q <= '0;
        end else begin
            state   <= state_n;
            aw_done <= aw_done_n;
            w_done  <= w_done_n;
            cnt     <= cnt_n;
            err     <= err_n;
            cause   <= cause_n;
            if (in_valid && in_ready) begin
                addr_q  <= in_addr;
                wdata_q <= f_wdata;
                wstrb_q <= f_wstrb;
            end
        end
    end
endmodule
